if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline inside processor_top.
- Owns the PC register and drives the instruction memory address. Latches the IF/ID pipeline register consumed by the decode stage.
- Honours stall from the hazard unit and PC redirect from EX (branch/jal taken).
- Detects the terminal self-loop `jal x0,0` and raises a sticky halt, so benches can stop on `halt_o` instead of running a fixed cycle budget.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (`addi x0,x0,0`) placed in IF/ID on flush or halt.
- HALT_WORD, 32'h0000_006F, encoding of `jal x0,0`.
- HALT_REDIRECTS, 2, consecutive qualifying redirects required to assert halt (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hazard unit: hold PC and IF/ID.
- redirect_i  in  1  EX: control transfer taken, flush IF/ID.
- redirect_pc_i  in  32  EX: target PC.
- imem_addr_o  out  32  byte address to instruction memory (combinational read).
- imem_rdata_i  in  32  instruction word at imem_addr_o, same cycle.
- ifid_pc_o  out  32  PC of latched instruction.
- ifid_pc4_o  out  32  ifid_pc_o + 4.
- ifid_instr_o  out  32  latched instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- halt_o  out  1  sticky halt flag.
- fetch_count_o  out  32  valid fetches latched since reset.

Behaviour:
- Reset (async, asserted at any time, including mid-stall or mid-redirect):
  - pc=RESET_PC, ifid_pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_valid=0.
  - halt_o=0, fetch_count=0, halt counter=0, last target=0, target-is-halt flag=0.
- imem_addr_o = pc, combinational. Memory read latency is 0, so IF/ID contents appear 1 cycle after the PC is presented.
- Priority per cycle: halted > redirect > stall > normal.
  - Halted:
    - pc frozen; IF/ID forced to {pc, NOP_INSTR, valid=0}.
    - redirect_i and stall_i ignored; fetch_count frozen.
  - Redirect (redirect_i=1, also when stall_i=1):
    - pc <= {redirect_pc_i[31:2], 2'b00}; misaligned targets are silently aligned.
    - IF/ID <= {pc, NOP_INSTR, valid=0}; the wrong-path word is discarded.
  - Stall (redirect_i=0, stall_i=1): pc and all IF/ID fields hold; count holds.
  - Normal:
    - IF/ID <= {pc, imem_rdata_i, valid=1}; pc <= pc+4 (mod 2^32, wrap from 0xFFFFFFFC to 0).
    - fetch_count += 1, saturating at 0xFFFFFFFF.
- ifid_pc4_o = ifid_pc_o + 4, combinational from the register.
- Halt detection (sub-module):
  - On the first normal fetch after a redirect, capture tgt_is_halt = (imem_rdata_i == HALT_WORD), for the word at the redirect target.
  - On each redirect with target T: if T == last_target and tgt_is_halt=1, then cnt <= cnt+1; otherwise cnt <= 0.
  - In both cases last_target <= T.
  - halt_o sets on the edge where cnt reaches HALT_REDIRECTS and stays set until reset.
  - A wrong-path fetch of HALT_WORD never halts: it is flushed before any repeated redirect to its address. Loop heads that are not HALT_WORD never halt.
- No combinational path from redirect_i or stall_i to any ifid_* output. Only imem_addr_o depends on state.

Decomposition:
- pipeline_pkg holds:
  - constants NOP_INSTR, HALT_WORD, RESET_PC_DEFAULT;
  - typedef struct ifid_t {pc, instr, valid}, shared with id_stage.
- One sub-module, halt_detector: inputs redirect event, target, first-fetch strobe, fetched word; output halt. Holds last_target, tgt_is_halt and a 4-bit counter.
- The PC mux and IF/ID register stay in if_stage.

Test Plan:
- Reset then 3 normal cycles with imem returning 0xA, 0xB, 0xC:
  - before the first edge, IF/ID reads {0, NOP, 0};
  - afterwards ifid_pc = 0, 4, 8 with instr A, B, C, valid=1, and fetch_count=3.
- Stall for 2 cycles at pc=8:
  - IF/ID holds {4, B, 1}, imem_addr_o stays 8, fetch_count unchanged;
  - release gives {8, C} and pc=0xC.
- redirect_i=1 with stall_i=1, target 0x157:
  - next cycle pc=0x154 and IF/ID {prev pc, NOP_INSTR, 0};
  - next fetch latches pc 0x154.
- Program ending `jal x0,0` at 0x158, with EX redirecting to 0x158 every third cycle:
  - halt_o=1 on the edge of the 2nd repeated redirect;
  - afterwards pc stays 0x158, ifid_valid=0, count frozen.
- Loop with repeated redirects to 0x58 (word 0x00E6A5B3): halt_o never asserts after 50 iterations.
- Assert rst mid-stall, asynchronously between edges: outputs reach reset values immediately, and halt clears if it was set.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the RV32I 5-stage core.
//   RESET_PC_DEFAULT : PC loaded on reset
//   NOP_INSTR        : bubble word (addi x0,x0,0)
//   HALT_WORD        : encoding of the terminal self-loop jal x0,0
//   ifid_t           : IF/ID pipeline register, consumed by id_stage
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] HALT_WORD        = 32'h0000_006F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    // Instruction fetches are word aligned; low address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_halt_detector.sv
// Detects the terminal `jal x0,0` self-loop from the redirect stream.
//   clk, rst     : clock, asynchronous active-high reset
//   redirect     : a redirect is being accepted this cycle
//   target       : aligned redirect target
//   first_fetch  : first normal fetch after a redirect
//   fetch_word   : instruction word fetched this cycle
//   halt         : sticky halt flag
module halt_detector #(
    parameter logic [31:0] HALT_WORD      = pipeline_pkg::HALT_WORD,
    parameter int          HALT_REDIRECTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        first_fetch,
    input  logic [31:0] fetch_word,
    output logic        halt
);
    import pipeline_pkg::*;

    localparam logic [3:0] HALT_LIMIT = 4'(HALT_REDIRECTS);

    logic [31:0] last_target;
    logic        tgt_is_halt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_inc;
    logic        repeat_hit;

    // A redirect only counts if it returns to the same target and the word
    // seen there after the previous redirect was the halt encoding. A
    // wrong-path HALT_WORD is never captured because capture happens only
    // on the first fetch after a redirect.
    assign repeat_hit = (target == last_target) && tgt_is_halt;
    assign cnt_inc    = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_target <= '0;
            tgt_is_halt <= 1'b0;
            cnt         <= '0;
            halt        <= 1'b0;
        end else begin
            if (first_fetch) begin
                tgt_is_halt <= (fetch_word == HALT_WORD);
            end
            if (redirect) begin
                last_target <= target;
                if (repeat_hit) begin
                    cnt <= cnt_inc;
                    if (cnt_inc >= HALT_LIMIT) begin
                        halt <= 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction memory address and the
// IF/ID pipeline register. Priority per cycle: halted > redirect > stall >
// normal fetch.
//   clk, rst        : clock, asynchronous active-high reset
//   stall_i         : hold PC and IF/ID
//   redirect_i      : taken control transfer from EX, flushes IF/ID
//   redirect_pc_i   : redirect target (aligned to a word here)
//   imem_addr_o     : instruction memory address (= pc)
//   imem_rdata_i    : instruction word at imem_addr_o, same cycle
//   ifid_pc_o/pc4_o : PC of latched instruction and PC+4
//   ifid_instr_o    : latched instruction
//   ifid_valid_o    : IF/ID holds a real instruction
//   halt_o          : sticky halt flag
//   fetch_count_o   : saturating count of valid fetches since reset
module if_stage #(
    parameter logic [31:0] RESET_PC       = pipeline_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR      = pipeline_pkg::NOP_INSTR,
    parameter logic [31:0] HALT_WORD      = pipeline_pkg::HALT_WORD,
    parameter int          HALT_REDIRECTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        halt_o,
    output logic [31:0] fetch_count_o
);
    import pipeline_pkg::*;

    logic [31:0] pc;
    logic [31:0] pc_next;
    ifid_t       ifid_q;
    ifid_t       ifid_d;
    logic [31:0] fetch_count;
    logic        after_redirect;
    logic        halted;
    logic        redirect_evt;
    logic        normal_fetch;
    logic [31:0] redirect_target;

    assign redirect_target = align_word(redirect_pc_i);
    assign redirect_evt    = redirect_i && !halted;
    assign normal_fetch    = !halted && !redirect_i && !stall_i;

    // NOTE: every signal driven here gets a default first, so no path
    // through the if/else chain can leave one unassigned and infer a latch.
    always_comb begin
        pc_next = pc;
        ifid_d  = ifid_q;
        if (halted) begin
            ifid_d = '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
        end else if (redirect_i) begin
            pc_next = redirect_target;
            ifid_d  = '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
        end else if (!stall_i) begin
            pc_next = pc + 32'd4;
            ifid_d  = '{pc: pc, instr: imem_rdata_i, valid: 1'b1};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order. The IF/ID
    // register is reset as well: decode must see a bubble, not garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            ifid_q         <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
            fetch_count    <= '0;
            after_redirect <= 1'b0;
        end else begin
            pc     <= pc_next;
            ifid_q <= ifid_d;
            if (normal_fetch && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            // Marks that the next normal fetch reads the redirect target.
            if (redirect_evt) begin
                after_redirect <= 1'b1;
            end else if (normal_fetch) begin
                after_redirect <= 1'b0;
            end
        end
    end

    halt_detector #(
        .HALT_WORD      (HALT_WORD),
        .HALT_REDIRECTS (HALT_REDIRECTS)
    ) u_halt_detector (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect_evt),
        .target      (redirect_target),
        .first_fetch (normal_fetch && after_redirect),
        .fetch_word  (imem_rdata_i),
        .halt        (halted)
    );

    assign imem_addr_o   = pc;
    assign ifid_pc_o     = ifid_q.pc;
    assign ifid_pc4_o    = ifid_q.pc + 32'd4;
    assign ifid_instr_o  = ifid_q.instr;
    assign ifid_valid_o  = ifid_q.valid;
    assign halt_o        = halted;
    assign fetch_count_o = fetch_count;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import pipeline_pkg::*;

    localparam int H = 2;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        halt_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [0:255];
    assign imem_rdata_i = mem[imem_addr_o[9:2]];

    if_stage #(.HALT_REDIRECTS(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o),
        .halt_o        (halt_o),
        .fetch_count_o (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural view of the fetch stage.
    typedef struct {
        logic [31:0] target;
        bit          cap;
    } redir_t;

    logic [31:0] m_pc, m_ifid_pc, m_instr, m_count;
    bit          m_valid, m_halt, m_pending, m_cap;
    redir_t      hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifid_pc = 32'h0; m_instr = NOP_INSTR; m_count = 32'h0;
        m_valid = 0; m_halt = 0; m_pending = 0; m_cap = 0;
        hist.delete();
    endtask

    // Halt when the last H redirects each returned to the previous target
    // after having seen HALT_WORD there.
    function automatic bit streak_halt();
        int n = hist.size();
        if (n < H + 1) return 0;
        for (int k = n - H; k < n; k++) begin
            if (!(hist[k].target == hist[k-1].target && hist[k].cap)) return 0;
        end
        return 1;
    endfunction

    task automatic model_step(input bit s, input bit r, input logic [31:0] t);
        logic [31:0] word = mem[m_pc[9:2]];
        if (m_halt) begin
            m_ifid_pc = m_pc; m_instr = NOP_INSTR; m_valid = 0;
        end else if (r) begin
            hist.push_back('{target: t & 32'hFFFF_FFFC, cap: m_cap});
            if (streak_halt()) m_halt = 1;
            m_ifid_pc = m_pc; m_instr = NOP_INSTR; m_valid = 0;
            m_pc = t & 32'hFFFF_FFFC;
            m_pending = 1;
        end else if (!s) begin
            if (m_pending) begin
                m_cap = (word == HALT_WORD);
                m_pending = 0;
            end
            m_ifid_pc = m_pc; m_instr = word; m_valid = 1;
            m_pc = m_pc + 32'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".addr"},  imem_addr_o,   m_pc);
        check({tag, ".pc"},    ifid_pc_o,     m_ifid_pc);
        check({tag, ".pc4"},   ifid_pc4_o,    m_ifid_pc + 32'd4);
        check({tag, ".instr"}, ifid_instr_o,  m_instr);
        check({tag, ".valid"}, ifid_valid_o,  m_valid);
        check({tag, ".halt"},  halt_o,        m_halt);
        check({tag, ".count"}, fetch_count_o, m_count);
    endtask

    task automatic step(input string tag, input bit s, input bit r, input logic [31:0] t);
        stall_i = s; redirect_i = r; redirect_pc_i = t;
        @(posedge clk);
        model_step(s, r, t);
        #1;
        compare_all(tag);
    endtask

    // Reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".halt_clr"}, halt_o, 32'h0);
        #1;
        rst = 1'b0;
    endtask

    initial begin : main
        bit          s, r;
        logic [31:0] t;
        int unsigned roll;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_WORD) mem[i] = 32'h0000_0033;
        end
        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
        mem[32'h158 >> 2] = HALT_WORD;
        mem[32'h58 >> 2]  = 32'h00E6_A5B3;

        rst = 1'b1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        model_reset();
        #2;
        check("rst.pc",    ifid_pc_o,     32'h0);
        check("rst.instr", ifid_instr_o,  NOP_INSTR);
        check("rst.valid", ifid_valid_o,  32'h0);
        check("rst.addr",  imem_addr_o,   32'h0);
        check("rst.count", fetch_count_o, 32'h0);
        check("rst.halt",  halt_o,        32'h0);
        #1;
        rst = 1'b0;

        // Two normal fetches, a two-cycle stall at pc=8, then release.
        step("n0", 0, 0, 0);
        check("n0.instrA", ifid_instr_o, 32'hA);
        step("n1", 0, 0, 0);
        check("n1.pc4", ifid_pc_o, 32'h4);
        step("st0", 1, 0, 0);
        step("st1", 1, 0, 0);
        check("st.addr",  imem_addr_o,   32'h8);
        check("st.instr", ifid_instr_o,  32'hB);
        check("st.count", fetch_count_o, 32'h2);
        step("rel", 0, 0, 0);
        check("rel.pc",    ifid_pc_o,     32'h8);
        check("rel.instr", ifid_instr_o,  32'hC);
        check("rel.addr",  imem_addr_o,   32'hC);
        check("rel.count", fetch_count_o, 32'h3);

        // Redirect wins over stall; misaligned target is aligned.
        step("rd", 1, 1, 32'h157);
        check("rd.addr",  imem_addr_o,  32'h154);
        check("rd.pc",    ifid_pc_o,    32'hC);
        check("rd.valid", ifid_valid_o, 32'h0);
        step("rdf", 0, 0, 0);
        check("rdf.pc", ifid_pc_o, 32'h154);

        // Terminal jal x0,0 at 0x158, EX redirecting every third cycle.
        for (int j = 0; j < 3; j++) begin
            step("hl.n", 0, 0, 0);
            step("hl.n", 0, 0, 0);
            step("hl.r", 0, 1, 32'h158);
            check("hl.halt_edge", halt_o, (j == 2) ? 32'h1 : 32'h0);
        end
        for (int j = 0; j < 4; j++) begin
            step("hd", $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            check("hd.addr",  imem_addr_o,   32'h158);
            check("hd.valid", ifid_valid_o,  32'h0);
            check("hd.count", fetch_count_o, 32'd10);
        end

        // Asynchronous reset mid-stall while halted.
        stall_i = 1'b1;
        async_reset("arst");

        // Loop head at 0x58 is not the halt word.
        for (int j = 0; j < 50; j++) begin
            step("lp.r", 0, 1, 32'h58);
            step("lp.n", 0, 0, 0);
            step("lp.n", 0, 0, 0);
        end
        check("lp.nohalt", halt_o, 32'h0);

        // PC wrap at the top of the address space.
        step("wr.r", 0, 1, 32'hFFFF_FFFE);
        check("wr.addr", imem_addr_o, 32'hFFFF_FFFC);
        step("wr.n", 0, 0, 0);
        check("wr.pc",   ifid_pc_o,   32'hFFFF_FFFC);
        check("wr.pc4",  ifid_pc4_o,  32'h0);
        check("wr.wrap", imem_addr_o, 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            roll = $urandom_range(0, 99);
            if (roll < 2) begin
                stall_i = $urandom_range(0, 1);
                async_reset("rnd.arst");
            end else begin
                s = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 4) == 0);
                case ($urandom_range(0, 3))
                    0:       t = 32'h158;
                    1:       t = 32'h15B;
                    2:       t = 32'h58;
                    default: t = $urandom_range(0, 1023);
                endcase
                step("rnd", s, r, t);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
